// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller. Decides, every cycle, which pipeline banks
// (PC, F/D, D/E, E/M, M/W) hold their contents and which load a bubble.
// Decisions are purely combinational from the current inputs and the
// registered controller state, so the banks act on them at the very next
// rising edge.
//
// Ports
//   clk, global_rst             clock and synchronous active-high reset
//   read_reg_1_FD/read_reg_2_FD decode-stage source register numbers
//   uses_reg_1_FD/uses_reg_2_FD decode instruction really reads that source
//   write_reg_sel_DE            execute-stage destination register
//   reg_write_en_DE             execute instruction writes a register
//   mem_enable_DE               execute instruction accesses data memory
//   mem_write_en_DE             execute instruction is a store
//   branch_taken_EX             execute redirects the PC this edge
//   imem_stall, dmem_stall      memory not ready
//   dump_MW                     halt instruction in writeback
//   freeze_*                    hold the corresponding register
//   clr_*                       load all-zero bubble into the bank
//   hazard_state                00 RUN, 01 DISCARD, 10 HALT
//   stall_count                 saturating count of stalled fetch cycles
//   flush_count                 saturating count of applied branch flushes
// ---------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        clk,
    input  logic        global_rst,
    input  logic [2:0]  read_reg_1_FD,
    input  logic [2:0]  read_reg_2_FD,
    input  logic        uses_reg_1_FD,
    input  logic        uses_reg_2_FD,
    input  logic [2:0]  write_reg_sel_DE,
    input  logic        reg_write_en_DE,
    input  logic        mem_enable_DE,
    input  logic        mem_write_en_DE,
    input  logic        branch_taken_EX,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    input  logic        dump_MW,
    output logic        freeze_PC,
    output logic        freeze_FD,
    output logic        freeze_DE,
    output logic        freeze_EM,
    output logic        clr_FD,
    output logic        clr_DE,
    output logic        clr_EM,
    output logic        clr_MW,
    output logic [1:0]  hazard_state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DISCARD = 2'b01,
        HALT    = 2'b10
    } state_t;

    state_t state;
    state_t next_state;
    logic   load_use;
    logic   flush_applied;

    // A load in execute whose destination feeds a source the decode
    // instruction actually reads cannot be forwarded in time.
    always_comb begin
        load_use = mem_enable_DE && !mem_write_en_DE && reg_write_en_DE &&
                   ((uses_reg_1_FD && (read_reg_1_FD == write_reg_sel_DE)) ||
                    (uses_reg_2_FD && (read_reg_2_FD == write_reg_sel_DE)));
    end

    // Priority-ordered hazard decisions. In DISCARD the F/D bank is bubbled
    // whenever it is allowed to load, including the cycle the stale fetch
    // finally returns; during a dmem stall F/D is frozen instead, so the
    // bubble is deferred until the stall releases.
    always_comb begin
        freeze_PC     = 1'b0;
        freeze_FD     = 1'b0;
        freeze_DE     = 1'b0;
        freeze_EM     = 1'b0;
        clr_FD        = 1'b0;
        clr_DE        = 1'b0;
        clr_EM        = 1'b0;
        clr_MW        = 1'b0;
        flush_applied = 1'b0;

        if (global_rst) begin
            // everything released while in reset
        end else if (state == HALT) begin
            freeze_PC = 1'b1;
            clr_FD    = 1'b1;
        end else if (dmem_stall) begin
            freeze_PC = 1'b1;
            freeze_FD = 1'b1;
            freeze_DE = 1'b1;
            freeze_EM = 1'b1;
            clr_MW    = 1'b1;
        end else begin
            if (branch_taken_EX) begin
                clr_FD        = 1'b1;
                clr_DE        = 1'b1;
                flush_applied = 1'b1;
            end else if (load_use) begin
                freeze_PC = 1'b1;
                freeze_FD = 1'b1;
                clr_DE    = 1'b1;
            end else if (imem_stall) begin
                freeze_PC = 1'b1;
                clr_FD    = 1'b1;
            end

            if (state == DISCARD) begin
                clr_FD = 1'b1;
            end
        end
    end

    // Next-state logic. A redirect while the fetch is still outstanding
    // means the instruction eventually returned belongs to the old path, so
    // DISCARD remembers to drop it. Halt waits for any dmem stall to clear.
    always_comb begin
        next_state = state;
        if (dump_MW && !dmem_stall) begin
            next_state = HALT;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken_EX && imem_stall && !dmem_stall) begin
                        next_state = DISCARD;
                    end
                end
                DISCARD: begin
                    if (!imem_stall && !dmem_stall) begin
                        next_state = RUN;
                    end
                end
                HALT:    next_state = HALT;
                default: next_state = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Saturating performance counters; frozen while halted.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            stall_count <= 16'h0000;
            flush_count <= 16'h0000;
        end else begin
            if (freeze_PC && (state != HALT) && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'h0001;
            end
            if (flush_applied && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'h0001;
            end
        end
    end

    assign hazard_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Inputs change on the falling edge, the
// combinational decisions are sampled 1 ns later, the rising edge commits
// state, and registered outputs are sampled at the following falling edge.
// The eight decision outputs are compared as one vector ordered
// {freeze_PC, freeze_FD, freeze_DE, freeze_EM, clr_FD, clr_DE, clr_EM, clr_MW}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        global_rst;
    logic [2:0]  read_reg_1_FD;
    logic [2:0]  read_reg_2_FD;
    logic        uses_reg_1_FD;
    logic        uses_reg_2_FD;
    logic [2:0]  write_reg_sel_DE;
    logic        reg_write_en_DE;
    logic        mem_enable_DE;
    logic        mem_write_en_DE;
    logic        branch_taken_EX;
    logic        imem_stall;
    logic        dmem_stall;
    logic        dump_MW;
    logic        freeze_PC;
    logic        freeze_FD;
    logic        freeze_DE;
    logic        freeze_EM;
    logic        clr_FD;
    logic        clr_DE;
    logic        clr_EM;
    logic        clr_MW;
    logic [1:0]  hazard_state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    logic [7:0]  ctrl;
    int          n_checks;
    int          n_fail;

    assign ctrl = {freeze_PC, freeze_FD, freeze_DE, freeze_EM,
                   clr_FD, clr_DE, clr_EM, clr_MW};

    hazard_ctrl dut (
        .clk              (clk),
        .global_rst       (global_rst),
        .read_reg_1_FD    (read_reg_1_FD),
        .read_reg_2_FD    (read_reg_2_FD),
        .uses_reg_1_FD    (uses_reg_1_FD),
        .uses_reg_2_FD    (uses_reg_2_FD),
        .write_reg_sel_DE (write_reg_sel_DE),
        .reg_write_en_DE  (reg_write_en_DE),
        .mem_enable_DE    (mem_enable_DE),
        .mem_write_en_DE  (mem_write_en_DE),
        .branch_taken_EX  (branch_taken_EX),
        .imem_stall       (imem_stall),
        .dmem_stall       (dmem_stall),
        .dump_MW          (dump_MW),
        .freeze_PC        (freeze_PC),
        .freeze_FD        (freeze_FD),
        .freeze_DE        (freeze_DE),
        .freeze_EM        (freeze_EM),
        .clr_FD           (clr_FD),
        .clr_DE           (clr_DE),
        .clr_EM           (clr_EM),
        .clr_MW           (clr_MW),
        .hazard_state     (hazard_state),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return all hazard sources to their idle values.
    task clear_inputs;
        global_rst       = 1'b0;
        read_reg_1_FD    = 3'd0;
        read_reg_2_FD    = 3'd0;
        uses_reg_1_FD    = 1'b0;
        uses_reg_2_FD    = 1'b0;
        write_reg_sel_DE = 3'd0;
        reg_write_en_DE  = 1'b0;
        mem_enable_DE    = 1'b0;
        mem_write_en_DE  = 1'b0;
        branch_taken_EX  = 1'b0;
        imem_stall       = 1'b0;
        dmem_stall       = 1'b0;
        dump_MW          = 1'b0;
    endtask

    // Commit one rising edge and come back to the falling edge.
    task tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Load into r3 sitting in execute.
    task load_r3_in_de;
        write_reg_sel_DE = 3'd3;
        reg_write_en_DE  = 1'b1;
        mem_enable_DE    = 1'b1;
        mem_write_en_DE  = 1'b0;
    endtask

    task do_reset;
        clear_inputs();
        global_rst = 1'b1;
        tick();
        global_rst = 1'b0;
    endtask

    task test_reset;
        clear_inputs();
        global_rst      = 1'b1;
        dmem_stall      = 1'b1;
        branch_taken_EX = 1'b1;
        imem_stall      = 1'b1;
        dump_MW         = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_0000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, 8'b0000_0000);
        end
        tick();
        n_checks++;
        if (hazard_state !== 2'b00 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: got state=%b stall=%0d flush=%0d expected 00/0/0",
                     hazard_state, stall_count, flush_count);
        end
        clear_inputs();
    endtask

    task test_load_use;
        do_reset();
        load_r3_in_de();
        read_reg_1_FD = 3'd3;
        uses_reg_1_FD = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b1100_0100) begin
            n_fail++;
            $display("[TB] FAIL load_use_stall: got %b expected %b", ctrl, 8'b1100_0100);
        end
        tick();
        // execute now holds the bubble
        mem_enable_DE   = 1'b0;
        reg_write_en_DE = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_0000 || stall_count !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL load_use_one_cycle: got ctrl=%b stall=%0d expected 00000000/1",
                     ctrl, stall_count);
        end
        tick();
        // same registers, but decode does not read source 1
        load_r3_in_de();
        uses_reg_1_FD = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_0000) begin
            n_fail++;
            $display("[TB] FAIL load_use_unused_src: got %b expected %b", ctrl, 8'b0000_0000);
        end
        // a store to r3 is not a load-use even if decode reads r3
        uses_reg_1_FD   = 1'b1;
        mem_write_en_DE = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_0000) begin
            n_fail++;
            $display("[TB] FAIL load_use_store: got %b expected %b", ctrl, 8'b0000_0000);
        end
        // second source path
        mem_write_en_DE = 1'b0;
        uses_reg_1_FD   = 1'b0;
        read_reg_1_FD   = 3'd0;
        read_reg_2_FD   = 3'd3;
        uses_reg_2_FD   = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b1100_0100) begin
            n_fail++;
            $display("[TB] FAIL load_use_src2: got %b expected %b", ctrl, 8'b1100_0100);
        end
        tick();
        clear_inputs();
        n_checks++;
        if (stall_count !== 16'd2 || flush_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL load_use_counts: got stall=%0d flush=%0d expected 2/0",
                     stall_count, flush_count);
        end
    endtask

    task test_branch_load_use;
        do_reset();
        load_r3_in_de();
        read_reg_1_FD   = 3'd3;
        uses_reg_1_FD   = 1'b1;
        branch_taken_EX = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_1100) begin
            n_fail++;
            $display("[TB] FAIL branch_over_load_use: got %b expected %b", ctrl, 8'b0000_1100);
        end
        tick();
        clear_inputs();
        n_checks++;
        if (flush_count !== 16'd1 || stall_count !== 16'd0 || hazard_state !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL branch_counts: got flush=%0d stall=%0d state=%b expected 1/0/00",
                     flush_count, stall_count, hazard_state);
        end
    endtask

    task test_dmem_branch;
        do_reset();
        branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_stall = 1'b1;
            #1;
            n_checks++;
            if (ctrl !== 8'b1111_0001) begin
                n_fail++;
                $display("[TB] FAIL dmem_stall_cycle%0d: got %b expected %b", i, ctrl, 8'b1111_0001);
            end
            tick();
        end
        dmem_stall = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_1100) begin
            n_fail++;
            $display("[TB] FAIL dmem_then_flush: got %b expected %b", ctrl, 8'b0000_1100);
        end
        tick();
        clear_inputs();
        n_checks++;
        if (flush_count !== 16'd1 || stall_count !== 16'd3) begin
            n_fail++;
            $display("[TB] FAIL dmem_counts: got flush=%0d stall=%0d expected 1/3",
                     flush_count, stall_count);
        end
    endtask

    task test_discard;
        do_reset();
        branch_taken_EX = 1'b1;
        imem_stall      = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_1100) begin
            n_fail++;
            $display("[TB] FAIL discard_entry_ctrl: got %b expected %b", ctrl, 8'b0000_1100);
        end
        tick();
        branch_taken_EX = 1'b0;
        n_checks++;
        if (hazard_state !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL discard_state: got %b expected 01", hazard_state);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ctrl !== 8'b1000_1000 || hazard_state !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL discard_hold%0d: got ctrl=%b state=%b expected 10001000/01",
                         i, ctrl, hazard_state);
            end
            tick();
        end
        imem_stall = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_1000) begin
            n_fail++;
            $display("[TB] FAIL discard_release: got %b expected %b", ctrl, 8'b0000_1000);
        end
        tick();
        n_checks++;
        if (hazard_state !== 2'b00 || flush_count !== 16'd1 || stall_count !== 16'd2) begin
            n_fail++;
            $display("[TB] FAIL discard_exit: got state=%b flush=%0d stall=%0d expected 00/1/2",
                     hazard_state, flush_count, stall_count);
        end
        // re-enter DISCARD, then a dmem stall must not force clr_FD
        branch_taken_EX = 1'b1;
        imem_stall      = 1'b1;
        tick();
        branch_taken_EX = 1'b0;
        imem_stall      = 1'b0;
        dmem_stall      = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b1111_0001) begin
            n_fail++;
            $display("[TB] FAIL discard_dmem: got %b expected %b", ctrl, 8'b1111_0001);
        end
        tick();
        n_checks++;
        if (hazard_state !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL discard_dmem_state: got %b expected 01", hazard_state);
        end
        // reset in the middle of DISCARD
        dmem_stall = 1'b0;
        imem_stall = 1'b1;
        global_rst = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (hazard_state !== 2'b00 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL discard_reset: got state=%b stall=%0d flush=%0d expected 00/0/0",
                     hazard_state, stall_count, flush_count);
        end
    endtask

    task test_halt;
        do_reset();
        // dump blocked by a concurrent dmem stall
        dump_MW    = 1'b1;
        dmem_stall = 1'b1;
        tick();
        n_checks++;
        if (hazard_state !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL halt_wait_dmem: got %b expected 00", hazard_state);
        end
        dmem_stall = 1'b0;
        tick();
        dump_MW = 1'b0;
        n_checks++;
        if (hazard_state !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL halt_entry: got %b expected 10", hazard_state);
        end
        for (int i = 0; i < 20; i++) begin
            branch_taken_EX = i[0];
            imem_stall      = i[1];
            dmem_stall      = i[2];
            #1;
            n_checks++;
            if (ctrl !== 8'b1000_1000 || hazard_state !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL halt_hold%0d: got ctrl=%b state=%b expected 10001000/10",
                         i, ctrl, hazard_state);
            end
            tick();
        end
        n_checks++;
        if (stall_count !== 16'd1 || flush_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL halt_counts: got stall=%0d flush=%0d expected 1/0",
                     stall_count, flush_count);
        end
        clear_inputs();
        global_rst = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 8'b0000_0000) begin
            n_fail++;
            $display("[TB] FAIL halt_reset_ctrl: got %b expected %b", ctrl, 8'b0000_0000);
        end
        tick();
        global_rst = 1'b0;
        n_checks++;
        if (hazard_state !== 2'b00 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL halt_reset: got state=%b stall=%0d flush=%0d expected 00/0/0",
                     hazard_state, stall_count, flush_count);
        end
    endtask

    task test_saturate;
        do_reset();
        imem_stall = 1'b1;
        repeat (65534) tick();
        n_checks++;
        if (stall_count !== 16'hFFFE) begin
            n_fail++;
            $display("[TB] FAIL sat_before: got %h expected fffe", stall_count);
        end
        tick();
        n_checks++;
        if (stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL sat_reach: got %h expected ffff", stall_count);
        end
        repeat (4465) tick();
        n_checks++;
        if (stall_count !== 16'hFFFF || hazard_state !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: got stall=%h state=%b expected ffff/00",
                     stall_count, hazard_state);
        end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_dmem_branch();
        test_discard();
        test_halt();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
